// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and alignment helper for the data-memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // True when the access width does not fit its natural alignment.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    mis = 1'b0;
    case (size)
      SZ_HALF: mis = addr_lo[0];
      SZ_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response bus between the MEM stage and the data-memory controller.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering: store enables/replication and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        uns_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] raw_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane enables, replicated store data and extended load data from size/offset.
  always_comb begin
    be_o     = 4'b1111;
    wdata_o  = wdata_i;
    rdata_o  = raw_i;
    shifted  = raw_i >> {addr_lo_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo_i[1] ? raw_i[31:16] : raw_i[15:0];
    case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = uns_i ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_HALF: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = uns_i ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = raw_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with valid/ready request port, wait states and error reporting.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  dmem_if.slave bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               ready_q;
  logic               resp_valid_q;
  logic [31:0]        rdata_q;
  logic               err_q;
  logic               we_q;
  logic [1:0]         size_q;
  logic               uns_q;
  logic [31:0]        addr_q;
  logic [31:0]        wdata_q;

  logic [31:0]        mem_q [DEPTH];

  logic               hs_c;
  logic               access_c;
  logic               err_c;
  logic [AW-1:0]      idx_c;
  logic [3:0]         be_c;
  logic [31:0]        wrep_c;
  logic [31:0]        load_c;
  logic [31:0]        rdata_d;

  assign hs_c     = bus.req_valid && ready_q;
  assign access_c = (state_q == WAIT) && (cnt_q == '0);
  assign idx_c    = addr_q[AW+1:2];
  assign err_c    = is_misaligned(size_q, addr_q[1:0]) || (size_q == 2'd3) ||
                    (addr_q[31:2] >= 30'(DEPTH));
  assign rdata_d  = (we_q || err_c) ? 32'h0 : load_c;

  dmem_lane_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .uns_i     (uns_q),
    .wdata_i   (wdata_q),
    .raw_i     (mem_q[idx_c]),
    .be_o      (be_c),
    .wdata_o   (wrep_c),
    .rdata_o   (load_c)
  );

  // Request FSM: accept in IDLE/RESP, count wait states, access and respond.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      we_q         <= 1'b0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE, RESP: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
          if (hs_c) begin
            we_q    <= bus.req_we;
            size_q  <= bus.req_size;
            uns_q   <= bus.req_unsigned;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            cnt_q   <= CNT_W'(LATENCY);
            ready_q <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            resp_valid_q <= 1'b1;
            rdata_q      <= rdata_d;
            err_q        <= err_c;
            ready_q      <= 1'b1;
            state_q      <= RESP;
          end
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Byte-lane writes on the access edge of a valid store; the array has no reset.
  always_ff @(posedge clk) begin
    if (access_c && we_q && !err_c) begin
      for (int i = 0; i < 4; i++) begin
        if (be_c[i]) mem_q[idx_c][8*i +: 8] <= wrep_c[8*i +: 8];
      end
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule
